// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//   Command FIFO plus result register wrapped around an external 8-bit
//   combinational ALU. Commands {A, B, sel} arrive on a valid/ready
//   handshake and are buffered in a DEPTH-entry FIFO. The FIFO head drives
//   the ALU directly. On issue, the ALU result and flags are captured in a
//   result register, which is offered downstream on a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream command handshake
//   in_a, in_b, in_sel       command operands and op select
//   alu_a, alu_b, alu_sel    FIFO head to the ALU (zero when empty)
//   alu_out, alu_zero,
//   alu_carry                ALU result and flags
//   res_valid/res_ready      downstream result handshake
//   res_data, res_zero,
//   res_carry                registered result; carry only kept for ADD/SUB
//   count                    current FIFO occupancy
// ---------------------------------------------------------------------------
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [2:0]               in_sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [2:0]               alu_sel,
  input  logic [W-1:0]             alu_out,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic                     res_zero,
  output logic                     res_carry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * W + 3;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  // FIFO storage, entry layout {a, b, sel}
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q,  res_data_d;
  logic          res_zero_q,  res_zero_d;
  logic          res_carry_q, res_carry_d;

  logic          empty;
  logic          push;
  logic          issue;
  logic [EW-1:0] head;
  logic [W-1:0]  head_a;
  logic [W-1:0]  head_b;
  logic [2:0]    head_sel;

  assign empty    = (count_q == '0);
  // Full is judged from state only: a pop in the same cycle does not open a slot.
  assign in_ready = (count_q < DEPTH_CNT);
  assign push     = in_valid & in_ready;
  assign issue    = ~empty & (~res_valid_q | res_ready);

  assign head     = mem_q[rd_ptr_q];
  assign head_a   = head[EW-1 -: W];
  assign head_b   = head[W+2 -: W];
  assign head_sel = head[2:0];

  // Stale storage is masked so the ALU sees zeros while the queue is empty.
  assign alu_a   = empty ? '0 : head_a;
  assign alu_b   = empty ? '0 : head_b;
  assign alu_sel = empty ? 3'b000 : head_sel;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b, in_sel};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, issue})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_zero_d  = alu_zero;
      // Carry only has meaning for ADD (000) and SUB (001).
      res_carry_d = alu_carry & (head_sel[2:1] == 2'b00);
    end else if (res_valid_q & res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_carry = res_carry_q;
  assign count     = count_q;

endmodule
